// File: rtl/ddr_pkg.sv
// ddr_pkg: shared definitions for the DDR arrow source.
// Holds the generator FSM encoding, default arrow-mapping constants, the
// arrow code values and the default LFSR feedback mask / seed.
package ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } gen_state_t;

  localparam int DEF_ARROW_W    = 5;
  localparam int DEF_NUM_ARROWS = 4;
  localparam int DEF_ARROW_BASE = 10;

  // 16-bit maximal-length Galois mask (period 65535) and its default seed.
  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0001;

  typedef logic [DEF_ARROW_W-1:0] arrow_code_t;

  localparam arrow_code_t ARROW_LEFT  = 5'd10;
  localparam arrow_code_t ARROW_DOWN  = 5'd11;
  localparam arrow_code_t ARROW_UP    = 5'd12;
  localparam arrow_code_t ARROW_RIGHT = 5'd13;

endpackage

// File: rtl/arrow_lfsr_gen_if.sv
// arrow_lfsr_gen_if: valid/ready arrow stream from the generator to the scroller.
//   arrow_valid  source -> sink  head entry present
//   arrow        source -> sink  head arrow code (0 when nothing is valid)
//   arrow_ready  sink -> source  sink takes the head this cycle
interface arrow_lfsr_gen_if #(
  parameter int ARROW_W = 5
);
  logic               arrow_valid;
  logic [ARROW_W-1:0] arrow;
  logic               arrow_ready;

  modport master (output arrow_valid, output arrow, input arrow_ready);
  modport slave  (input arrow_valid, input arrow, output arrow_ready);
endinterface

// File: rtl/arrow_fifo.sv
// arrow_fifo: DEPTH x ARROW_W synchronous FIFO for pre-generated arrows.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush_i      empty the FIFO (wins over push/pop)
//   push_i       write din_i; taken when not full, or full with a pop
//   pop_i        drop the head; ignored when empty
//   din_i        code to write
//   dout_o       head code, 0 when empty
//   full_o       level == DEPTH
//   empty_o      level == 0
//   level_o      entries held, 0..DEPTH
module arrow_fifo #(
  parameter int DEPTH   = 8,
  parameter int ARROW_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ARROW_W-1:0]       din_i,
  output logic [ARROW_W-1:0]       dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ARROW_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !rst) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;
endmodule

// File: rtl/arrow_lfsr_gen.sv
// arrow_lfsr_gen: Galois-LFSR arrow source with prefill FIFO.
// After a seed load the FIFO is prefilled one arrow per clock; afterwards one
// arrow is generated per metronome step. Arrows leave through a valid/ready
// interface. Optional macro ARROW_LFSR_REPEAT_LIMIT_EN enables the limiter on
// consecutive identical arrows (MAX_REPEAT); without it the raw index is used.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   seed_load_i    load seed (0 -> DEFAULT_SEED) and restart prefill
//   seed_i         seed value
//   step_i         metronome tick (one-cycle pulse), used in RUN only
//   arr_if         master side of the arrow stream
//   random_num_o   current LFSR state
//   fill_level_o   FIFO entries held
//   overflow_o     sticky: a generated arrow was dropped on a full FIFO
module arrow_lfsr_gen
  import ddr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(DEF_SEED),
  parameter int               NUM_ARROWS   = DEF_NUM_ARROWS,
  parameter int               ARROW_BASE   = DEF_ARROW_BASE,
  parameter int               ARROW_W      = DEF_ARROW_W,
  parameter int               DEPTH        = 8,
  parameter int               MAX_REPEAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_load_i,
  input  logic [WIDTH-1:0]       seed_i,
  input  logic                   step_i,
  arrow_lfsr_gen_if.master       arr_if,
  output logic [WIDTH-1:0]       random_num_o,
  output logic [$clog2(DEPTH):0] fill_level_o,
  output logic                   overflow_o
);
  localparam int IDX_W = $clog2(NUM_ARROWS);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (WIDTH < 4)       begin : g_chk_width $error("WIDTH must be at least 4"); end
  if (NUM_ARROWS < 2)  begin : g_chk_arrows $error("NUM_ARROWS must be at least 2"); end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (MAX_REPEAT < 1)  begin : g_chk_repeat $error("MAX_REPEAT must be at least 1"); end

  gen_state_t         state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_adv, seed_val;
  logic [IDX_W-1:0]   raw_idx, push_idx;
  logic [ARROW_W-1:0] push_code, head_code;
  logic               gen, flush, pop, push_ok;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   level;
  logic               overflow_q, overflow_d;

  // A zero state would lock the LFSR; the next advance restarts from the seed.
  assign lfsr_adv = (lfsr_q == '0) ? DEFAULT_SEED
                  : (lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1));
  assign seed_val = (seed_i == '0) ? DEFAULT_SEED : seed_i;
  assign raw_idx  = IDX_W'(lfsr_adv % WIDTH'(NUM_ARROWS));

  assign pop     = !fifo_empty && arr_if.arrow_ready;
  assign push_ok = gen && (!fifo_full || pop);

`ifdef ARROW_LFSR_REPEAT_LIMIT_EN
  localparam int RUN_W = $clog2(MAX_REPEAT + 1);

  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [RUN_W-1:0] run_q, run_d;

  // run_q == 0 means no arrow pushed since reset/seed load.
  always_comb begin
    push_idx   = raw_idx;
    last_idx_d = last_idx_q;
    run_d      = run_q;
    if (raw_idx == last_idx_q && run_q == RUN_W'(MAX_REPEAT))
      push_idx = (raw_idx == IDX_W'(NUM_ARROWS - 1)) ? '0 : raw_idx + IDX_W'(1);
    if (seed_load_i) begin
      last_idx_d = '0;
      run_d      = '0;
    end else if (push_ok) begin
      last_idx_d = push_idx;
      run_d      = (run_q != '0 && push_idx == last_idx_q) ? run_q + RUN_W'(1) : RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q <= '0;
      run_q      <= '0;
    end else begin
      last_idx_q <= last_idx_d;
      run_q      <= run_d;
    end
  end
`else
  assign push_idx = raw_idx;
`endif

  assign push_code = ARROW_W'(ARROW_BASE) + ARROW_W'(push_idx);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    gen     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seed_load_i) begin
          lfsr_d  = seed_val;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (seed_load_i) begin
          flush  = 1'b1;
          lfsr_d = seed_val;
        end else if (fifo_full && !pop) begin
          state_d = ST_RUN;
        end else begin
          gen    = 1'b1;
          lfsr_d = lfsr_adv;
          if (level + LVL_W'(1) - LVL_W'(pop) == LVL_W'(DEPTH)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seed_load_i) begin
          flush   = 1'b1;
          lfsr_d  = seed_val;
          state_d = ST_FILL;
        end else if (step_i) begin
          gen    = 1'b1;
          lfsr_d = lfsr_adv;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Generated but not accepted means the FIFO was full without a pop.
  assign overflow_d = overflow_q | (gen && !push_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= DEFAULT_SEED;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      overflow_q <= overflow_d;
    end
  end

  arrow_fifo #(
    .DEPTH   (DEPTH),
    .ARROW_W (ARROW_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push_ok),
    .pop_i   (pop),
    .din_i   (push_code),
    .dout_o  (head_code),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign arr_if.arrow_valid = !fifo_empty;
  assign arr_if.arrow       = head_code;
  assign random_num_o       = lfsr_q;
  assign fill_level_o       = level;
  assign overflow_o         = overflow_q;
endmodule

// File: doc/arrow_lfsr_gen.md
Name: arrow_lfsr_gen

Overview:
- Parametrised successor to the single-register random arrow source used by the DDR game core.
- Runs a Galois LFSR of configurable width and taps, with seed load and lock-up protection.
- Maps LFSR state to arrow codes and pre-buffers upcoming arrows in a small FIFO with a valid/ready handshake to the scroller.
- Sits between the metronome tick and the arrow display/scoring path.

Parameters:
- WIDTH, 16, LFSR state width (minimum 4).
- TAPS, 16'hB400, Galois feedback mask (default is maximal length 65535).
- DEFAULT_SEED, 1, substituted whenever a zero seed is loaded.
- NUM_ARROWS, 4, number of distinct arrows (minimum 2).
- ARROW_BASE, 10, code offset added to the arrow index.
- ARROW_W, 5, arrow code width.
- DEPTH, 8, FIFO entries (power of two, minimum 2).
- MAX_REPEAT, 2, maximum consecutive identical pushed arrows.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seed_load  in  1  load seed and start prefill
- seed  in  WIDTH  seed value (switches)
- step  in  1  metronome tick, one-cycle pulse
- arrow_ready  in  1  consumer accepts head
- arrow_valid  out  1  FIFO non-empty
- arrow  out  ARROW_W  FIFO head code; 0 when empty
- random_num  out  WIDTH  current LFSR state
- fill_level  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky; a generated arrow was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: LFSR=DEFAULT_SEED, FIFO empty, arrow_valid=0, arrow=0, fill_level=0, overflow=0, FSM=IDLE, run counters cleared.
- Reset mid-operation: rst wins over every other input in the same cycle and discards FIFO contents.
- LFSR advance: if s[0]==1, next = (s>>1)^TAPS; otherwise next = s>>1.
- Seed load: loads seed, or DEFAULT_SEED if seed==0.
- Arrow derivation: idx = next_state % NUM_ARROWS, computed on the post-advance state. Pushed code = ARROW_BASE + idx (after repeat limiting).
- Repeat limiter: tracks last pushed idx and its run length. If idx equals the last pushed idx and the run length equals MAX_REPEAT, push (idx+1)%NUM_ARROWS instead and set the run to 1.
- FSM IDLE: no generation. seed_load -> FILL.
- FSM FILL: advances one LFSR step and pushes one arrow every clk until the FIFO is full -> RUN. step is ignored during FILL.
- FSM RUN: each step advances the LFSR and pushes one arrow. If the FIFO is full with no pop that cycle, the arrow is dropped and overflow is set. The LFSR still advances.
- seed_load in FILL or RUN: FIFO flushed, run counters cleared, reload seed, -> FILL (overflow unchanged).
- Handshake: a pop occurs when arrow_valid && arrow_ready. arrow/arrow_valid are registered from the FIFO head, and a pushed entry is visible the cycle after the push.
- Simultaneous push and pop on a full FIFO: both happen, and the level is unchanged.
- Simultaneous push and pop on an empty FIFO: push only. Pop is impossible because valid=0.
- Lock-up guard: if the LFSR state is ever 0 (SEU/bad TAPS), the next advance loads DEFAULT_SEED.
- Pointers wrap modulo DEPTH; fill_level ranges 0..DEPTH.

Optional Feature:
- Macro: ARROW_LFSR_REPEAT_LIMIT_EN.
- Defined: repeat limiter active as described above.
- Undefined: raw idx is pushed, the run counter logic is absent, and MAX_REPEAT is ignored.

Decomposition:
- Shared package ddr_pkg holds:
  - FSM encoding (IDLE/FILL/RUN);
  - ARROW_BASE and NUM_ARROWS defaults;
  - arrow code constants (10..13);
  - default TAPS/DEFAULT_SEED;
  - arrow_code_t typedef of ARROW_W bits.
- One sub-module, arrow_fifo: parametrised DEPTH×ARROW_W synchronous FIFO with push/pop/full/empty/level.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> random_num=0x0001, arrow_valid=0, arrow=0, fill_level=0. No change on step while IDLE.
- seed_load with seed=0x0001, limiter enabled -> FILL for 8 cycles. LFSR passes 0xB400, 0x5A00, 0x2D00, 0x1680, 0x0B40, 0x05A0, 0x02D0, 0x0168. FIFO holds 10,10,11,10,10,11,10,10, and fill_level=8.
- Same stimulus with ARROW_LFSR_REPEAT_LIMIT_EN undefined -> FIFO holds eight 10s.
- RUN with full FIFO, arrow_ready=0, one step -> overflow=1, fill_level stays 8, random_num=0x00B4.
- RUN with full FIFO, arrow_ready=1 and step in the same cycle -> head 10 popped, new arrow 12 (state 0x005A, idx 2) pushed at the tail, fill_level stays 8.
- seed_load with seed=0 mid-RUN -> FIFO flushed, state reloads 0x0001, and prefill repeats the scenario-2 sequence. rst asserted during FILL -> all outputs return to reset values the next cycle.
